// File: rtl/serial_transmitter.sv
// rtl/serial_transmitter.sv - FIFO-buffered serial frame transmitter
//
// Purpose: bytes written by a controller are queued in an internal FIFO and
// sent one frame each: start bit (0), DataLen data bits LSB first, optional
// parity bit, StopBit stop bits (1). Each bit lasts ClkDivider clocks.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   data_in      byte to queue
//   write        push data_in this cycle (dropped while full)
//   full         FIFO holds Depth bytes
//   empty        FIFO holds no pending bytes
//   busy         a frame is in progress
//   serial_line  registered serial output, idle high

module serial_transmitter #(
  parameter int ClkDivider = 5,
  parameter int DataLen    = 8,
  parameter int Parity     = 1,
  parameter int ParityEven = 1,
  parameter int StopBit    = 1,
  parameter int Depth      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DataLen-1:0] data_in,
  input  logic               write,
  output logic               full,
  output logic               empty,
  output logic               busy,
  output logic               serial_line
);

  localparam int PtrW   = $clog2(Depth);
  localparam int CntW   = $clog2(Depth + 1);
  localparam int DivW   = $clog2(ClkDivider);
  localparam int BitMax = (DataLen > StopBit) ? DataLen : StopBit;
  localparam int BitW   = $clog2(BitMax + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [DataLen-1:0] mem [Depth];
  logic [PtrW-1:0]    wr_ptr;
  logic [PtrW-1:0]    rd_ptr;
  logic [CntW-1:0]    count;

  // Frame engine
  state_t             state;
  logic [DivW-1:0]    div_cnt;
  logic [BitW-1:0]    bit_cnt;
  logic [DataLen-1:0] shift;
  logic [DataLen-1:0] shift_next;
  logic               par_bit;
  logic               line_q;

  logic               wr_en;
  logic               div_last;
  logic               stop_done;
  logic               load;
  logic [DataLen-1:0] head;

  assign full        = (count == CntW'(Depth));
  assign empty       = (count == '0);
  assign busy        = (state != IDLE);
  assign serial_line = line_q;

  assign wr_en      = write & ~full;
  assign div_last   = (div_cnt == DivW'(ClkDivider - 1));
  assign stop_done  = (state == STOP) && div_last && (bit_cnt == BitW'(StopBit - 1));
  assign head       = mem[rd_ptr];
  assign shift_next = shift >> 1;

  // The load edge is the only point where a byte leaves the FIFO: either
  // from IDLE, or at the end of the last stop bit for back-to-back frames.
  assign load = ~empty & ((state == IDLE) | stop_done);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PtrW'(1);
      end
      if (load) begin
        rd_ptr <= rd_ptr + PtrW'(1);
      end
      case ({wr_en, load})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
      line_q  <= 1'b1;
    end else if (load) begin
      state   <= START;
      div_cnt <= '0;
      bit_cnt <= '0;
      shift   <= head;
      par_bit <= (ParityEven != 0) ? ^head : ~^head;
      line_q  <= 1'b0;
    end else if (state == IDLE) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      line_q  <= 1'b1;
    end else if (!div_last) begin
      div_cnt <= div_cnt + DivW'(1);
    end else begin
      div_cnt <= '0;
      case (state)
        START: begin
          state   <= DATA;
          bit_cnt <= '0;
          line_q  <= shift[0];
        end
        DATA: begin
          if (bit_cnt == BitW'(DataLen - 1)) begin
            bit_cnt <= '0;
            if (Parity != 0) begin
              state  <= PARITY;
              line_q <= par_bit;
            end else begin
              state  <= STOP;
              line_q <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + BitW'(1);
            shift   <= shift_next;
            line_q  <= shift_next[0];
          end
        end
        PARITY: begin
          state   <= STOP;
          bit_cnt <= '0;
          line_q  <= 1'b1;
        end
        STOP: begin
          // Reaching the last stop bit with bytes pending is handled by load.
          if (bit_cnt == BitW'(StopBit - 1)) begin
            state   <= IDLE;
            bit_cnt <= '0;
          end else begin
            bit_cnt <= bit_cnt + BitW'(1);
          end
          line_q <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          line_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_transmitter.sv
// tb/tb_serial_transmitter.sv - scoreboard bench for serial_transmitter in four configurations

module tb_serial_transmitter;

  localparam int DL    = 8;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       write = 1'b0;
  bit         chk_en = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Config 0: defaults. 1: odd parity. 2: no parity. 3: ClkDivider=2, StopBit=2.
  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int CD  = (g == 3) ? 2 : 5;
    localparam int PAR = (g == 2) ? 0 : 1;
    localparam int PEV = (g == 1) ? 0 : 1;
    localparam int SB  = (g == 3) ? 2 : 1;
    localparam int NB  = 1 + DL + PAR + SB;
    localparam int FL  = NB * CD;

    logic full, empty, busy, sline;

    serial_transmitter #(
      .ClkDivider(CD), .DataLen(DL), .Parity(PAR),
      .ParityEven(PEV), .StopBit(SB), .Depth(DEPTH)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .write(write),
      .full(full), .empty(empty), .busy(busy), .serial_line(sline)
    );

    // Reference model: a queue of pending bytes plus a frame timer.
    logic [7:0] fifo_m[$];
    logic [7:0] sb_q[$];
    logic [7:0] cur = 8'h00;
    int         cnt = 0;
    int         tx_rem = 0;
    int         c0;
    bit         acc, pop;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        fifo_m.delete();
        sb_q.delete();
        cnt = 0;
        tx_rem = 0;
      end else begin
        c0  = fifo_m.size();
        acc = write && (c0 < DEPTH);
        if (tx_rem > 0) tx_rem--;
        pop = (tx_rem == 0) && (c0 > 0);
        if (pop) begin
          cur = fifo_m.pop_front();
          tx_rem = FL;
        end
        if (acc) begin
          fifo_m.push_back(data_in);
          sb_q.push_back(data_in);
        end
        cnt = fifo_m.size();
      end
    end

    // Cycle-level expectations derived from the frame position.
    logic el;
    int   pos, bi;
    always @(negedge clk) begin
      if (chk_en) begin
        el = 1'b1;
        if (tx_rem > 0) begin
          pos = FL - tx_rem;
          bi  = pos / CD;
          if (bi == 0) el = 1'b0;
          else if (bi <= DL) el = cur[bi-1];
          else if (bi == DL + 1 && PAR == 1) el = (PEV == 1) ? ^cur : ~^cur;
        end
        check($sformatf("c%0d_line", g), int'(sline), int'(el));
        check($sformatf("c%0d_busy", g), int'(busy), int'(tx_rem > 0));
        check($sformatf("c%0d_full", g), int'(full), int'(cnt == DEPTH));
        check($sformatf("c%0d_empty", g), int'(empty), int'(cnt == 0));
      end
    end

    // Monitor: decode frames from the line and compare with the scoreboard.
    bit          mon_act = 1'b0;
    int          mon_cnt = 0;
    int          frames_seen = 0;
    logic [15:0] fbits, exp_f, mask;
    logic [7:0]  eb;
    always @(negedge clk) begin
      if (!rst_n || !chk_en) begin
        mon_act = 1'b0;
      end else begin
        if (!mon_act && sline == 1'b0) begin
          mon_act = 1'b1;
          mon_cnt = 0;
          fbits   = '1;
        end
        if (mon_act) begin
          if (mon_cnt % CD == CD / 2) fbits[mon_cnt / CD] = sline;
          mon_cnt++;
          if (mon_cnt == FL) begin
            mon_act = 1'b0;
            frames_seen++;
            if (sb_q.size() == 0) begin
              check($sformatf("c%0d_unexpected_frame", g), int'(fbits[8:1]), -1);
            end else begin
              eb = sb_q.pop_front();
              exp_f = '1;
              exp_f[0] = 1'b0;
              exp_f[DL:1] = eb;
              if (PAR == 1) exp_f[DL+1] = (PEV == 1) ? ^eb : ~^eb;
              mask = 16'((32'd1 << NB) - 1);
              check($sformatf("c%0d_frame_data", g), int'(fbits[DL:1]), int'(eb));
              check($sformatf("c%0d_frame_bits", g), int'(fbits & mask), int'(exp_f & mask));
            end
          end
        end
      end
    end
  end

  int b0, b1, b2, b3, fs0;
  bit hit;

  task automatic send_one(input logic [7:0] d, input int wait_cycles);
    write = 1'b1;
    data_in = d;
    @(negedge clk);
    write = 1'b0;
    repeat (wait_cycles) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("reset_line", int'(g_cfg[0].sline), 1);
    check("reset_busy", int'(g_cfg[0].busy), 0);
    check("reset_full", int'(g_cfg[0].full), 0);
    check("reset_empty", int'(g_cfg[0].empty), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single 0xA5: latency and busy duration in every configuration.
    write = 1'b1;
    data_in = 8'hA5;
    @(negedge clk);
    write = 1'b0;
    check("lat_before_line", int'(g_cfg[0].sline), 1);
    check("lat_empty", int'(g_cfg[0].empty), 0);
    b0 = 0; b1 = 0; b2 = 0; b3 = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (i == 0) check("lat_line", int'(g_cfg[0].sline), 0);
      if (g_cfg[0].busy) b0++;
      if (g_cfg[1].busy) b1++;
      if (g_cfg[2].busy) b2++;
      if (g_cfg[3].busy) b3++;
    end
    check("busy_len_default", b0, 55);
    check("busy_len_odd", b1, 55);
    check("busy_len_nopar", b2, 50);
    check("busy_len_fast", b3, 24);
    check("idle_empty", int'(g_cfg[0].empty), 1);

    send_one(8'h07, 70);
    send_one(8'hFF, 70);

    // Ten consecutive writes: the FSM pops the first, so the tenth is dropped.
    for (int i = 1; i <= 10; i++) begin
      write = 1'b1;
      data_in = 8'(i);
      @(negedge clk);
    end
    write = 1'b0;
    check("fill_full", int'(g_cfg[0].full), 1);

    // Write while full on the exact pop edge.
    hit = 1'b0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      if (g_cfg[0].tx_rem == 1 && g_cfg[0].cnt == DEPTH) hit = 1'b1;
      else @(negedge clk);
    end
    check("pop_edge_reached", int'(hit), 1);
    write = 1'b1;
    data_in = 8'h5A;
    @(negedge clk);
    write = 1'b0;
    check("drop_full", int'(g_cfg[0].full), 0);
    write = 1'b1;
    data_in = 8'h3C;
    @(negedge clk);
    write = 1'b0;
    check("refill_full", int'(g_cfg[0].full), 1);

    // Reset during data bit 4 with three bytes queued.
    hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      if (g_cfg[0].cnt == 3 && g_cfg[0].tx_rem > 0 && (55 - g_cfg[0].tx_rem) / 5 == 5) hit = 1'b1;
      else @(negedge clk);
    end
    check("rst_point_reached", int'(hit), 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_line", int'(g_cfg[0].sline), 1);
    check("rst_mid_busy", int'(g_cfg[0].busy), 0);
    check("rst_mid_empty", int'(g_cfg[0].empty), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    fs0 = g_cfg[0].frames_seen;
    repeat (100) @(negedge clk);
    check("no_frame_after_reset", g_cfg[0].frames_seen, fs0);
    check("idle_after_reset", int'(g_cfg[0].busy), 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      write = ($urandom_range(0, 2) == 0);
      data_in = 8'($urandom);
      @(negedge clk);
    end
    write = 1'b0;

    hit = 1'b0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      if (g_cfg[0].cnt == 0 && g_cfg[0].tx_rem == 0 &&
          g_cfg[1].cnt == 0 && g_cfg[1].tx_rem == 0 &&
          g_cfg[2].cnt == 0 && g_cfg[2].tx_rem == 0 &&
          g_cfg[3].cnt == 0 && g_cfg[3].tx_rem == 0) hit = 1'b1;
      else @(negedge clk);
    end
    check("drain_done", int'(hit), 1);
    repeat (5) @(negedge clk);
    check("c0_sb_left", g_cfg[0].sb_q.size(), 0);
    check("c1_sb_left", g_cfg[1].sb_q.size(), 0);
    check("c2_sb_left", g_cfg[2].sb_q.size(), 0);
    check("c3_sb_left", g_cfg[3].sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
